// File: rtl/la_dsel_pkg.sv
// Shared definitions for the la_dsel family of one-hot select generators:
// requester count, index width, FSM state encoding and a one-hot decoder.
package la_dsel_pkg;

  localparam int N    = 7;
  localparam int IDXW = 3;

  // Pointer value after reset: the agent "granted last" is 6, so the first
  // round-robin search begins at agent 0.
  localparam logic [IDXW-1:0] LAST_RST = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // One-hot (or zero) vector to binary index. OR-reduction of the set bit
  // positions; with a zero vector the result is 0.
  function automatic logic [IDXW-1:0] onehot2idx(input logic [N-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/la_rrpick7.sv
// Combinational 7-way picker. In rotate mode the search starts just after
// last_i and wraps 6->0, so the previous winner has lowest priority. In
// fixed mode the lowest asserted index wins and last_i is ignored.
module la_rrpick7
  import la_dsel_pkg::*;
(
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  input  logic            fixed_i,
  output logic [N-1:0]    grant_o,
  output logic            any_o
);

  logic            found;
  logic [IDXW-1:0] pos;
  int              pos_int;

  // Walk the seven candidates in priority order and take the first request.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = '0;
    pos_int = 0;
    for (int k = 0; k < N; k++) begin
      if (fixed_i) begin
        pos_int = k;
      end else begin
        pos_int = (int'(last_i) + 1 + k) % N;
      end
      pos = IDXW'(pos_int);
      if (!found && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/la_dsel7.sv
// Registered 7-way select generator. A grant is taken from IDLE on any
// request and held in BUSY until the grantee pulses done; on done the next
// winner is granted at the same edge, or the block returns to IDLE. All
// outputs come straight from flops, so req/done never reach them
// combinationally.
//
// Handshake: req is a level; a grant (sel/valid/gidx) is issued at a rising
// edge and is held unchanged until an edge where done=1, at which point it
// either moves to the next winner or drops to zero. done outside BUSY and
// req changes during BUSY have no effect.
module la_dsel7
  import la_dsel_pkg::*;
#(
  parameter string PROP = "DEFAULT",
  parameter string MODE = "RR"
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req6,
  input  logic       req5,
  input  logic       req4,
  input  logic       req3,
  input  logic       req2,
  input  logic       req1,
  input  logic       req0,
  input  logic       done,
  output logic       sel6,
  output logic       sel5,
  output logic       sel4,
  output logic       sel3,
  output logic       sel2,
  output logic       sel1,
  output logic       sel0,
  output logic       valid,
  output logic [2:0] gidx
);

  localparam logic MODE_FIXED = (MODE == "FIXED");

  // Hook for implementation mapping of non-default cell properties; the
  // behavioural model is identical for every PROP value.
  if (PROP != "DEFAULT") begin : g_prop_custom
  end

  state_e          state_q, state_d;
  logic [IDXW-1:0] last_q,  last_d;
  logic [N-1:0]    sel_q,   sel_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] gidx_q,  gidx_d;

  logic [N-1:0]    req_vec;
  logic [N-1:0]    pick_grant;
  logic            pick_any;
  logic            grant_slot;

  assign req_vec = {req6, req5, req4, req3, req2, req1, req0};

  la_rrpick7 u_pick (
    .req_i   (req_vec),
    .last_i  (last_q),
    .fixed_i (MODE_FIXED),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  // A new arbitration happens when idle, or when the grantee finishes.
  assign grant_slot = (state_q == ST_IDLE) || done;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    gidx_d  = gidx_q;
    if (grant_slot) begin
      if (pick_any) begin
        state_d = ST_BUSY;
        sel_d   = pick_grant;
        valid_d = 1'b1;
        gidx_d  = onehot2idx(pick_grant);
        last_d  = onehot2idx(pick_grant);
      end else begin
        state_d = ST_IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        gidx_d  = '0;
      end
    end
  end

  // State, pointer and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      sel_q   <= '0;
      valid_q <= 1'b0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      gidx_q  <= gidx_d;
    end
  end

  assign {sel6, sel5, sel4, sel3, sel2, sel1, sel0} = sel_q;
  assign valid = valid_q;
  assign gidx  = gidx_q;

endmodule

// File: tb/tb_la_dsel7.sv
// Directed bench for la_dsel7: a round-robin instance and a fixed-priority
// instance, driven from vector tables plus hand sequences for async reset.
module tb_la_dsel7;

  typedef struct {
    logic       nrst;
    logic [6:0] req;
    logic       done;
    logic [6:0] exp_sel;
    logic [2:0] exp_gidx;
    logic       exp_valid;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;
  bit inv_on = 1'b0;

  // ---------------- DUTs ----------------
  logic       rr_nreset, rr_done;
  logic [6:0] rr_req;
  logic [6:0] rr_sel;
  logic       rr_valid;
  logic [2:0] rr_gidx;

  logic       fx_nreset, fx_done;
  logic [6:0] fx_req;
  logic [6:0] fx_sel;
  logic       fx_valid;
  logic [2:0] fx_gidx;

  la_dsel7 #(.PROP("DEFAULT"), .MODE("RR")) dut_rr (
    .clk(clk), .nreset(rr_nreset),
    .req6(rr_req[6]), .req5(rr_req[5]), .req4(rr_req[4]), .req3(rr_req[3]),
    .req2(rr_req[2]), .req1(rr_req[1]), .req0(rr_req[0]),
    .done(rr_done),
    .sel6(rr_sel[6]), .sel5(rr_sel[5]), .sel4(rr_sel[4]), .sel3(rr_sel[3]),
    .sel2(rr_sel[2]), .sel1(rr_sel[1]), .sel0(rr_sel[0]),
    .valid(rr_valid), .gidx(rr_gidx)
  );

  la_dsel7 #(.PROP("DEFAULT"), .MODE("FIXED")) dut_fx (
    .clk(clk), .nreset(fx_nreset),
    .req6(fx_req[6]), .req5(fx_req[5]), .req4(fx_req[4]), .req3(fx_req[3]),
    .req2(fx_req[2]), .req1(fx_req[1]), .req0(fx_req[0]),
    .done(fx_done),
    .sel6(fx_sel[6]), .sel5(fx_sel[5]), .sel4(fx_sel[4]), .sel3(fx_sel[3]),
    .sel2(fx_sel[2]), .sel1(fx_sel[1]), .sel0(fx_sel[0]),
    .valid(fx_valid), .gidx(fx_gidx)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name,
                     input logic [6:0] a_sel, input logic a_v, input logic [2:0] a_g,
                     input logic [6:0] e_sel, input logic e_v, input logic [2:0] e_g);
    n_vec++;
    if (a_sel !== e_sel || a_v !== e_v || a_g !== e_g) begin
      n_bad++;
      $display("FAIL %s: got sel=%h valid=%b gidx=%0d, expected sel=%h valid=%b gidx=%0d",
               name, a_sel, a_v, a_g, e_sel, e_v, e_g);
    end
  endtask

  // Structural invariant: sel one-hot or zero, valid == |sel, gidx == index(sel).
  task automatic inv(input string name, input logic [6:0] s, input logic v,
                     input logic [2:0] g);
    int       cnt;
    logic [2:0] idx;
    cnt = 0;
    idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (s[i] === 1'b1) begin
        cnt++;
        idx = 3'(i);
      end
    end
    n_vec++;
    if (cnt > 1 || v !== (cnt != 0) || g !== idx || $isunknown(s)) begin
      n_bad++;
      $display("FAIL %s: sel=%h valid=%b gidx=%0d, required onehot0 sel, valid=%b gidx=%0d",
               name, s, v, g, (cnt != 0), idx);
    end
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      inv("inv_rr", rr_sel, rr_valid, rr_gidx);
      inv("inv_fx", fx_sel, fx_valid, fx_gidx);
    end
  end

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input bit use_fx, input int id);
    string nm;
    @(negedge clk);
    if (use_fx) begin
      fx_nreset = v.nrst; fx_req = v.req; fx_done = v.done;
    end else begin
      rr_nreset = v.nrst; rr_req = v.req; rr_done = v.done;
    end
    @(posedge clk);
    #1;
    if (use_fx) begin
      nm = $sformatf("fx_vec%0d", id);
      chk(nm, fx_sel, fx_valid, fx_gidx, v.exp_sel, v.exp_valid, v.exp_gidx);
    end else begin
      nm = $sformatf("rr_vec%0d", id);
      chk(nm, rr_sel, rr_valid, rr_gidx, v.exp_sel, v.exp_valid, v.exp_gidx);
    end
  endtask

  function automatic vec_t mk(input logic nrst, input logic [6:0] req, input logic done,
                              input logic [6:0] es, input logic [2:0] eg, input logic ev);
    vec_t v;
    v.nrst = nrst; v.req = req; v.done = done;
    v.exp_sel = es; v.exp_gidx = eg; v.exp_valid = ev;
    return v;
  endfunction

  vec_t rr_tab[$];
  vec_t fx_tab[$];

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held over an edge, then release: agent 0 first.
    rr_tab.push_back(mk(1'b0, 7'h7F, 1'b0, 7'h00, 3'd0, 1'b0));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h01, 3'd0, 1'b1));
    // Rotation with all requesting and done every cycle.
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h02, 3'd1, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h04, 3'd2, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h08, 3'd3, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h10, 3'd4, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h20, 3'd5, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h40, 3'd6, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h7F, 1'b1, 7'h01, 3'd0, 1'b1));
    // Hold: grant 3, then req3 dropped / req5 raised without done.
    rr_tab.push_back(mk(1'b1, 7'h08, 1'b1, 7'h08, 3'd3, 1'b1));
    for (int i = 0; i < 5; i++)
      rr_tab.push_back(mk(1'b1, 7'h20, 1'b0, 7'h08, 3'd3, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h20, 1'b1, 7'h20, 3'd5, 1'b1));
    // Wrap and skip from last=5 with agents 0 and 2 requesting.
    rr_tab.push_back(mk(1'b1, 7'h05, 1'b1, 7'h01, 3'd0, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h05, 1'b1, 7'h04, 3'd2, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h00, 1'b1, 7'h00, 3'd0, 1'b0));
    rr_tab.push_back(mk(1'b1, 7'h00, 1'b1, 7'h00, 3'd0, 1'b0));
    // From idle (last=2): lone req1 wins after full wrap; held, then released.
    rr_tab.push_back(mk(1'b1, 7'h02, 1'b0, 7'h02, 3'd1, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h00, 1'b0, 7'h02, 3'd1, 1'b1));
    rr_tab.push_back(mk(1'b1, 7'h00, 1'b1, 7'h00, 3'd0, 1'b0));
    rr_tab.push_back(mk(1'b1, 7'h10, 1'b0, 7'h10, 3'd4, 1'b1));

    // Fixed priority: req=6A keeps picking agent 1, then 3, then 5.
    fx_tab.push_back(mk(1'b1, 7'h6A, 1'b1, 7'h02, 3'd1, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h6A, 1'b1, 7'h02, 3'd1, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h6A, 1'b1, 7'h02, 3'd1, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h6A, 1'b1, 7'h02, 3'd1, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h68, 1'b1, 7'h08, 3'd3, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h60, 1'b1, 7'h20, 3'd5, 1'b1));
    fx_tab.push_back(mk(1'b1, 7'h00, 1'b1, 7'h00, 3'd0, 1'b0));

    rr_nreset = 1'b1; rr_req = 7'h7F; rr_done = 1'b0;
    fx_nreset = 1'b1; fx_req = 7'h00; fx_done = 1'b0;
    #2;
    rr_nreset = 1'b0;
    fx_nreset = 1'b0;
    #1;
    chk("rr_reset_async", rr_sel, rr_valid, rr_gidx, 7'h00, 1'b0, 3'd0);
    chk("fx_reset_async", fx_sel, fx_valid, fx_gidx, 7'h00, 1'b0, 3'd0);
    inv_on = 1'b1;

    foreach (rr_tab[i]) run_vec(rr_tab[i], 1'b0, i);

    // Async reset in the middle of a BUSY cycle (agent 4 currently granted).
    @(posedge clk);
    #3;
    rr_nreset = 1'b0;
    #1;
    chk("rr_async_mid_busy", rr_sel, rr_valid, rr_gidx, 7'h00, 1'b0, 3'd0);
    run_vec(mk(1'b1, 7'h40, 1'b0, 7'h40, 3'd6, 1'b1), 1'b0, 100);
    // Pointer is now 6, so the next full search starts at agent 0.
    run_vec(mk(1'b1, 7'h7F, 1'b1, 7'h01, 3'd0, 1'b1), 1'b0, 101);

    foreach (fx_tab[i]) run_vec(fx_tab[i], 1'b1, i);

    @(negedge clk);
    inv_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
